// File: rtl/apb_protocol_checker_if.sv
// APB bus bundle shared by the fabric, the slaves and the passive checker.
// Latency: none, this is plain wiring.
// Backpressure: none here; PREADY is only carried through.
// Modports: master drives the request side, slave drives the response side,
// monitor observes every signal (used by apb_protocol_checker).
interface apb_protocol_checker_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 4
);
    logic [NUM_SLAVES-1:0] PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

    modport monitor (
        input PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_protocol_checker.sv
// Passive APB checker/recorder: tracks each transfer and flags protocol violations.
// Latency: record and error outputs are registered, one PCLK after the sampled edge.
// Backpressure: none; it only observes, so it never stalls the bus it watches.
// Ports: PCLK, PRESET (async, active-high), bus (monitor modport), clear (sync clear
// of sticky bits/counters); xfer_* transaction record with xfer_done pulse;
// err_valid/err_code/err_sticky violation reporting; xfer_count/err_count saturating.
// Build option: define APB_CHK_TIMEOUT_EN to abort transfers after TIMEOUT_CYCLES waits.
module apb_protocol_checker #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 16,
    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    apb_protocol_checker_if.monitor bus,
    input  logic                   clear,
    output logic                   xfer_done,
    output logic                   xfer_write,
    output logic [SW-1:0]          xfer_slave,
    output logic [ADDR_WIDTH-1:0]  xfer_addr,
    output logic [DATA_WIDTH-1:0]  xfer_data,
    output logic                   xfer_slverr,
    output logic [WW-1:0]          xfer_waits,
    output logic                   err_valid,
    output logic [2:0]             err_code,
    output logic [6:0]             err_sticky,
    output logic [CNT_WIDTH-1:0]   xfer_count,
    output logic [CNT_WIDTH-1:0]   err_count
);
    typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

    state_t                state, state_nxt;
    logic [NUM_SLAVES-1:0] cap_sel;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic                  cap_write;
    logic [DATA_WIDTH-1:0] cap_wdata;
    logic [WW-1:0]         wait_cnt, wait_nxt;
    logic [6:0]            vio;
    logic                  setup, complete, multi_sel;

    // Lowest set bit of the select vector; a legal select has exactly one.
    function automatic logic [SW-1:0] sel_index(input logic [NUM_SLAVES-1:0] sel);
        logic [SW-1:0] idx;
        idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (sel[i]) idx = SW'(i);
        end
        return idx;
    endfunction

    // Reported code is the lowest-numbered violation of the sample.
    function automatic logic [2:0] lowest_bit(input logic [6:0] v);
        logic [2:0] code;
        code = '0;
        for (int i = 6; i >= 0; i--) begin
            if (v[i]) code = 3'(i);
        end
        return code;
    endfunction

    assign multi_sel = ($countones(bus.PSEL) > 1);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        vio       = '0;
        setup     = 1'b0;
        complete  = 1'b0;
        vio[3]    = multi_sel;
        case (state)
            IDLE: begin
                if (bus.PENABLE) begin
                    vio[4]    = 1'b1;
                    state_nxt = RECOVER;
                end else if (|bus.PSEL) begin
                    setup     = 1'b1;
                    wait_nxt  = '0;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (!bus.PENABLE) begin
                    vio[0]    = 1'b1;
                    state_nxt = RECOVER;
                end else begin
                    vio[1] = (bus.PADDR != cap_addr) || (bus.PWRITE != cap_write) ||
                             (bus.PWDATA != cap_wdata);
                    vio[2] = (bus.PSEL != cap_sel);
                    vio[6] = bus.PSLVERR && !bus.PREADY;
                    if (bus.PREADY) begin
                        // Control/address glitches still complete, using captured values.
                        complete  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
`ifdef APB_CHK_TIMEOUT_EN
                        wait_nxt = wait_cnt + 1'b1;
                        if (wait_nxt == WW'(TIMEOUT_CYCLES)) begin
                            vio[5]    = 1'b1;
                            state_nxt = RECOVER;
                        end
`else
                        // No abort: wait count pins at the timeout value.
                        if (wait_cnt != WW'(TIMEOUT_CYCLES)) wait_nxt = wait_cnt + 1'b1;
`endif
                    end
                end
            end
            RECOVER: begin
                if (!(|bus.PSEL) && !bus.PENABLE) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cap_sel     <= '0;
            cap_addr    <= '0;
            cap_write   <= 1'b0;
            cap_wdata   <= '0;
            wait_cnt    <= '0;
            xfer_done   <= 1'b0;
            xfer_write  <= 1'b0;
            xfer_slave  <= '0;
            xfer_addr   <= '0;
            xfer_data   <= '0;
            xfer_slverr <= 1'b0;
            xfer_waits  <= '0;
            err_valid   <= 1'b0;
            err_code    <= '0;
            err_sticky  <= '0;
            xfer_count  <= '0;
            err_count   <= '0;
        end else begin
            wait_cnt <= wait_nxt;
            if (setup) begin
                cap_sel   <= bus.PSEL;
                cap_addr  <= bus.PADDR;
                cap_write <= bus.PWRITE;
                cap_wdata <= bus.PWDATA;
            end

            xfer_done <= complete;
            if (complete) begin
                xfer_write  <= cap_write;
                xfer_slave  <= sel_index(cap_sel);
                xfer_addr   <= cap_addr;
                xfer_data   <= cap_write ? cap_wdata : bus.PRDATA;
                xfer_slverr <= bus.PSLVERR;
                xfer_waits  <= wait_cnt;
            end

            err_valid <= |vio;
            if (|vio) err_code <= lowest_bit(vio);

            // clear wipes history, but an event in the same sample is still recorded.
            err_sticky <= (clear ? 7'd0 : err_sticky) | vio;

            if (clear)                                xfer_count <= CNT_WIDTH'(complete);
            else if (complete && !(&xfer_count))      xfer_count <= xfer_count + 1'b1;

            if (clear)                                err_count <= CNT_WIDTH'(|vio);
            else if ((|vio) && !(&err_count))         err_count <= err_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_apb_protocol_checker.sv
module tb_apb_protocol_checker;
    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int NS   = 4;
    localparam int TO   = 16;
    localparam int CW   = 16;
    localparam int CMAX = (1 << CW) - 1;
    localparam int SW   = 2;
    localparam int WW   = $clog2(TO + 1);

    logic          PCLK = 1'b0;
    logic          PRESET = 1'b1;
    logic          clear = 1'b0;
    logic          xfer_done, xfer_write, xfer_slverr, err_valid;
    logic [SW-1:0] xfer_slave;
    logic [AW-1:0] xfer_addr;
    logic [DW-1:0] xfer_data;
    logic [WW-1:0] xfer_waits;
    logic [2:0]    err_code;
    logic [6:0]    err_sticky;
    logic [CW-1:0] xfer_count, err_count;

    apb_protocol_checker_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS)) bus ();

    apb_protocol_checker #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS),
        .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .bus(bus), .clear(clear),
        .xfer_done(xfer_done), .xfer_write(xfer_write), .xfer_slave(xfer_slave),
        .xfer_addr(xfer_addr), .xfer_data(xfer_data), .xfer_slverr(xfer_slverr),
        .xfer_waits(xfer_waits), .err_valid(err_valid), .err_code(err_code),
        .err_sticky(err_sticky), .xfer_count(xfer_count), .err_count(err_count)
    );

    always #5 PCLK = ~PCLK;

    int         n_vec = 0;
    int         n_err = 0;
    int         exp_xfers = 0;
    int         exp_errs = 0;
    logic [6:0] exp_sticky = '0;

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        bus.PSEL    = '0;
        bus.PENABLE = 1'b0;
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
    endtask

    // Model: one violating sample adds its bits to sticky and one to the count.
    task automatic note_err(input logic [6:0] bits);
        exp_sticky = exp_sticky | bits;
        if (exp_errs < CMAX) exp_errs++;
    endtask

    // Legal transfer; expected record comes straight from what was driven.
    task automatic xfer(input int sl, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                        input int waits, input bit serr, input bit clr_at_end);
        int exp_w;
        bus.PSEL     = '0;
        bus.PSEL[sl] = 1'b1;
        bus.PENABLE  = 1'b0;
        bus.PWRITE   = wr;
        bus.PADDR    = a;
        bus.PWDATA   = wd;
        bus.PREADY   = 1'b0;
        bus.PSLVERR  = 1'b0;
        bus.PRDATA   = $urandom;
        step();
        chk("setup_no_done", 64'(xfer_done), 64'd0);
        bus.PENABLE = 1'b1;
        for (int i = 0; i < waits; i++) begin
            bus.PRDATA = $urandom;
            step();
        end
        bus.PREADY  = 1'b1;
        bus.PRDATA  = rd;
        bus.PSLVERR = serr;
        clear       = clr_at_end;
        step();
        clear = 1'b0;
        exp_w = (waits > TO) ? TO : waits;
        if (clr_at_end) begin
            exp_xfers  = 1;
            exp_errs   = 0;
            exp_sticky = '0;
        end else if (exp_xfers < CMAX) begin
            exp_xfers++;
        end
        chk("rec_done",   64'(xfer_done),   64'd1);
        chk("rec_slave",  64'(xfer_slave),  64'(sl));
        chk("rec_write",  64'(xfer_write),  64'(wr));
        chk("rec_addr",   64'(xfer_addr),   64'(a));
        chk("rec_data",   64'(xfer_data),   wr ? 64'(wd) : 64'(rd));
        chk("rec_slverr", 64'(xfer_slverr), 64'(serr));
        chk("rec_waits",  64'(xfer_waits),  64'(exp_w));
        chk("xfer_count", 64'(xfer_count),  64'(exp_xfers));
        chk("err_count",  64'(err_count),   64'(exp_errs));
        chk("no_err",     64'(err_valid),   64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_idle();
        bus.PWRITE = 1'b0;
        bus.PADDR  = '0;
        bus.PWDATA = '0;
        bus.PRDATA = '0;
        #3;
        chk("rst_done",   64'(xfer_done),  64'd0);
        chk("rst_data",   64'(xfer_data),  64'd0);
        chk("rst_code",   64'(err_code),   64'd0);
        chk("rst_sticky", 64'(err_sticky), 64'd0);
        chk("rst_xcnt",   64'(xfer_count), 64'd0);
        chk("rst_ecnt",   64'(err_count),  64'd0);
        step();
        step();
        PRESET = 1'b0;
        step();

        // Write to slave 1 with two wait states.
        xfer(1, 1'b1, 8'h3C, 32'hDEADBEEF, 32'h0, 2, 1'b0, 1'b0);
        chk("t1_sticky", 64'(err_sticky), 64'd0);
        bus_idle();
        step();
        chk("t1_done_pulse", 64'(xfer_done), 64'd0);

        // Back-to-back: zero-wait read from slave 3, then a write with no gap.
        xfer(3, 1'b0, 8'h40, 32'h0, 32'h12345678, 0, 1'b0, 1'b0);
        xfer(0, 1'b1, 8'h44, 32'h0BADF00D, 32'h0, 1, 1'b1, 1'b0);
        bus_idle();
        step();

        // Random legal traffic.
        for (int n = 0; n < 24; n++) begin
            xfer($urandom_range(0, NS - 1), 1'($urandom_range(0, 1)), AW'($urandom),
                 $urandom, $urandom, $urandom_range(0, 5), 1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                bus_idle();
                step();
            end
        end
        bus_idle();
        step();
        chk("rand_sticky", 64'(err_sticky), 64'd0);

        // PADDR changes during a wait state; record keeps the captured address.
        bus.PSEL = 4'b0001; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
        bus.PADDR = 8'h10; bus.PWDATA = 32'hCAFE0001; bus.PREADY = 1'b0;
        step();
        bus.PENABLE = 1'b1;
        step();
        chk("t3_wait1_ok", 64'(err_valid), 64'd0);
        bus.PADDR = 8'h14;
        step();
        note_err(7'b0000010);
        chk("t3_valid",  64'(err_valid),  64'd1);
        chk("t3_code",   64'(err_code),   64'd1);
        chk("t3_sticky", 64'(err_sticky), 64'(7'b0000010));
        chk("t3_ecnt",   64'(err_count),  64'(exp_errs));
        bus.PREADY = 1'b1;
        step();
        note_err(7'b0000010);
        if (exp_xfers < CMAX) exp_xfers++;
        chk("t3_done",  64'(xfer_done),  64'd1);
        chk("t3_addr",  64'(xfer_addr),  64'h10);
        chk("t3_waits", 64'(xfer_waits), 64'd2);
        chk("t3_xcnt",  64'(xfer_count), 64'(exp_xfers));
        chk("t3_ecnt2", 64'(err_count),  64'(exp_errs));
        bus_idle();
        step();
        chk("t3_code_hold", 64'(err_code), 64'd1);

        // Long wait.
`ifdef APB_CHK_TIMEOUT_EN
        bus.PSEL = 4'b0100; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = 8'h20; bus.PREADY = 1'b0;
        step();
        bus.PENABLE = 1'b1;
        for (int i = 1; i < TO; i++) step();
        chk("t4_pre_timeout", 64'(err_valid), 64'd0);
        step();
        note_err(7'b0100000);
        chk("t4_valid", 64'(err_valid), 64'd1);
        chk("t4_code",  64'(err_code),  64'd5);
        chk("t4_nodone", 64'(xfer_done), 64'd0);
        bus.PENABLE = 1'b0;
        step();
        chk("t4_recover_quiet", 64'(err_valid), 64'd0);
        bus.PENABLE = 1'b1;
        bus.PREADY  = 1'b1;
        step();
        chk("t4_recover_nob4", 64'(err_valid), 64'd0);
        chk("t4_recover_nodone", 64'(xfer_done), 64'd0);
        chk("t4_xcnt", 64'(xfer_count), 64'(exp_xfers));
        bus_idle();
        step();
        xfer(2, 1'b0, 8'h24, 32'h0, 32'h5A5A5A5A, 1, 1'b0, 1'b0);
`else
        xfer(2, 1'b0, 8'h20, 32'h0, 32'hA5A50F0F, TO, 1'b0, 1'b0);
`endif
        chk("t4_sticky", 64'(err_sticky), 64'(exp_sticky));
        bus_idle();
        step();

        // Clear, multi-select with PENABLE in IDLE, clear again, clear with fault.
        clear = 1'b1;
        step();
        clear = 1'b0;
        exp_xfers = 0; exp_errs = 0; exp_sticky = '0;
        chk("clr_sticky", 64'(err_sticky), 64'd0);
        chk("clr_xcnt",   64'(xfer_count), 64'd0);
        chk("clr_ecnt",   64'(err_count),  64'd0);
        bus.PSEL = 4'b0101; bus.PENABLE = 1'b1;
        step();
        chk("t5_valid",  64'(err_valid),  64'd1);
        chk("t5_code",   64'(err_code),   64'd3);
        chk("t5_sticky", 64'(err_sticky), 64'(7'b0011000));
        chk("t5_ecnt",   64'(err_count),  64'd1);
        bus_idle();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("t5_clr_sticky", 64'(err_sticky), 64'd0);
        chk("t5_clr_ecnt",   64'(err_count),  64'd0);
        chk("t5_clr_valid",  64'(err_valid),  64'd0);
        bus.PSEL = 4'b0110; bus.PENABLE = 1'b1;
        clear = 1'b1;
        step();
        clear = 1'b0;
        exp_errs = 1; exp_sticky = 7'b0011000;
        chk("t5_clrerr_sticky", 64'(err_sticky), 64'(exp_sticky));
        chk("t5_clrerr_ecnt",   64'(err_count),  64'd1);
        bus_idle();
        step();
        xfer(2, 1'b1, 8'h7F, 32'h01020304, 32'h0, 0, 1'b0, 1'b1);
        chk("t5_clrxfer_sticky", 64'(err_sticky), 64'd0);
        bus_idle();
        step();

        // Reset in the middle of a transfer drops it.
        bus.PSEL = 4'b0010; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
        bus.PADDR = 8'h55; bus.PWDATA = 32'h11112222;
        step();
        bus.PENABLE = 1'b1;
        step();
        PRESET = 1'b1;
        #2;
        chk("mrst_xcnt", 64'(xfer_count), 64'd0);
        chk("mrst_code", 64'(err_code),   64'd0);
        bus_idle();
        step();
        PRESET = 1'b0;
        exp_xfers = 0; exp_errs = 0; exp_sticky = '0;
        step();
        chk("mrst_nodone", 64'(xfer_done), 64'd0);
        chk("mrst_noerr",  64'(err_valid), 64'd0);
        xfer(0, 1'b0, 8'h01, 32'h0, 32'h87654321, 3, 1'b0, 1'b0);
        bus_idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
